// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//   Read-side packer for the rclk domain of an asynchronous FIFO. Pops WIDTH-bit
//   words (one-cycle registered RAM read) and packs RATIO consecutive words into
//   one RATIO*WIDTH-bit beat on a valid/ready stream. An explicit flush, or an
//   optional idle timeout, closes a partial beat with a contiguous lane mask.
//
//   Optional feature macro: PACKER_TIMEOUT_EN
//     defined   : a partial beat idle for TIMEOUT cycles is auto-flushed
//     undefined : partial beats wait for an explicit flush; TIMEOUT unused
//
// Ports
//   rclk     in   FIFO read clock (single clock domain)
//   rrst     in   asynchronous active-high reset
//   rempty   in   FIFO empty flag
//   rdata    in   FIFO read data, valid the cycle after an accepted rinc
//   rinc     out  FIFO read request, never high while rempty
//   flush    in   single-cycle pulse: emit the current partial beat
//   m_valid  out  output beat valid
//   m_ready  in   downstream accept
//   m_data   out  packed beat, first word in lane 0 (bits [WIDTH-1:0])
//   m_keep   out  per-lane valid mask, contiguous from lane 0
//   m_last   out  beat was closed by a flush or timeout
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   rempty,
    input  logic [WIDTH-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [RATIO*WIDTH-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last
);

    // One extra bit so the counter can also represent a full pack held
    // while the output register is still occupied.
    localparam int CW = $clog2(RATIO) + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t FULL      = cnt_t'(RATIO);
    localparam cnt_t LAST_LANE = cnt_t'(RATIO - 1);

    cnt_t                   cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [RATIO*WIDTH-1:0] pack_q, pack_d;
    logic                   m_valid_q, m_valid_d;
    logic [RATIO*WIDTH-1:0] m_data_q, m_data_d;
    logic [RATIO-1:0]       m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;

    logic                   timeout_hit;
    logic                   flush_eff;
    logic                   out_free;
    cnt_t                   cnt_cap;
    cnt_t                   occ;
    logic [RATIO*WIDTH-1:0] pack_cap;
    logic [RATIO-1:0]       keep_part;
    logic                   move_full, move_part, close_now, resolve;

`ifdef PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;

    assign timeout_hit = (idle_q == IW'(TIMEOUT));

    // Counts consecutive cycles where a partial pack sits waiting on an empty
    // FIFO; any capture or flush (including its own) restarts the count.
    always_comb begin
        idle_d = '0;
        if (!pend_q && !flush_eff && rempty && cnt_q != '0 && cnt_q != FULL)
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The flush pulse acts in its own cycle as well as through the latch, so a
    // flush with no read in flight closes the beat one cycle later.
    assign flush_eff = flush || flush_pend_q || timeout_hit;
    assign out_free  = !m_valid_q || m_ready;
    assign occ       = cnt_q + cnt_t'(pend_q);
    assign cnt_cap   = occ;

    // A read may also be issued in the cycle the last lane lands, provided the
    // finished beat can leave at the same edge; this keeps streaming bubble-free.
    assign close_now = pend_q && (cnt_q == LAST_LANE) && out_free;
    assign move_full = (cnt_cap == FULL) && out_free;
    assign move_part = flush_eff && !pend_q && (cnt_q != '0) && (cnt_q != FULL) && out_free;
    assign resolve   = flush_eff && (move_full || (!pend_q && (cnt_q == '0 || move_part)));

    assign rinc = !rempty && !flush_eff && !rrst && ((occ < FULL) || close_now);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        pack_cap  = pack_q;
        keep_part = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (pend_q && cnt_q == cnt_t'(i))
                pack_cap[i*WIDTH +: WIDTH] = rdata;
            keep_part[i] = (cnt_t'(i) < cnt_q);
        end

        pend_d       = rinc;
        flush_pend_d = flush_eff && !resolve;
        cnt_d        = cnt_cap;
        pack_d       = pack_cap;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;

        if (m_valid_q && m_ready)
            m_valid_d = 1'b0;

        // The pack is cleared on every move, so lanes not captured before a
        // flush read back as zero in the partial beat.
        if (move_full || move_part) begin
            cnt_d     = '0;
            pack_d    = '0;
            m_valid_d = 1'b1;
            m_data_d  = pack_cap;
            m_keep_d  = move_full ? '1 : keep_part;
            m_last_d  = !move_full;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            pack_q       <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            flush_pend_q <= flush_pend_d;
            pack_q       <= pack_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//   Self-checking bench for fifo_rd_packer (WIDTH=8, RATIO=4, TIMEOUT=16).
//   A queue-based FIFO with a registered read feeds the DUT. A word-level model
//   groups pushed words into expected beats; a negedge compare process checks
//   every transferred beat, output stability under backpressure and rinc vs
//   rempty. Directed tests add literal expectations and cycle counts.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        rclk    = 1'b0;
    logic        rrst    = 1'b1;
    logic        rempty  = 1'b1;
    logic [7:0]  rdata   = 8'h00;
    logic        flush   = 1'b0;
    logic        m_ready = 1'b0;
    logic        rinc;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    int checks = 0;
    int errors = 0;

    fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO with one-cycle registered read ----------------
    logic [7:0] fifo_q[$];
    logic [7:0] push_req[$];

    always @(posedge rclk) begin
        if (rinc && fifo_q.size() > 0)
            rdata <= fifo_q.pop_front();
        while (push_req.size() > 0)
            fifo_q.push_back(push_req.pop_front());
        rempty <= (fifo_q.size() == 0);
    end

    // ---------------- word-level packing model ----------------
    logic [7:0] acc_q[$];
    beat_t      exp_q[$];
    beat_t      obs_q[$];

    task automatic mdl_emit(input logic last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last;
        foreach (acc_q[i]) begin
            b.data[i*8 +: 8] = acc_q[i];
            b.keep[i]        = 1'b1;
        end
        exp_q.push_back(b);
        acc_q.delete();
    endtask

    task automatic mdl_push(input logic [7:0] w);
        push_req.push_back(w);
        acc_q.push_back(w);
        if (acc_q.size() == RATIO) mdl_emit(1'b0);
    endtask

    task automatic mdl_flush();
        if (acc_q.size() > 0) mdl_emit(1'b1);
    endtask

    // ---------------- compare process and cycle statistics ----------------
    int    stat_cyc, rinc_cnt, run, max_run, first_rinc, first_valid;
    logic  stall_q = 1'b0;
    beat_t held;

    task automatic clear_stats();
        stat_cyc    = 0;
        rinc_cnt    = 0;
        run         = 0;
        max_run     = 0;
        first_rinc  = -1;
        first_valid = -1;
    endtask

    always @(negedge rclk) begin
        if (rrst) begin
            stall_q = 1'b0;
        end else begin
            if (rinc) begin
                check("rinc_while_empty", rempty, 1'b0);
                rinc_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (first_rinc < 0) first_rinc = stat_cyc;
            end else begin
                run = 0;
            end
            if (m_valid && first_valid < 0) first_valid = stat_cyc;

            if (stall_q) begin
                check("stall_valid_held", m_valid, 1'b1);
                check("stall_beat_stable", {m_data, m_keep, m_last}, {held.data, held.keep, held.last});
            end

            if (m_valid && m_ready) begin
                beat_t cur;
                cur.data = m_data;
                cur.keep = m_keep;
                cur.last = m_last;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h last %0b, expected no beat", m_data, m_keep, m_last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_keep", m_keep, e.keep);
                    check("beat_last", m_last, e.last);
                end
                obs_q.push_back(cur);
            end

            stall_q   = m_valid && !m_ready;
            held.data = m_data;
            held.keep = m_keep;
            held.last = m_last;
        end
        stat_cyc++;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_beats", obs_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        clear_stats();

        // Reset values
        tick(2);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data",  m_data,  32'h0);
        check("rst_m_keep",  m_keep,  4'h0);
        check("rst_m_last",  m_last,  1'b0);
        check("rst_rinc",    rinc,    1'b0);
        rrst = 1'b0;
        tick(2);

        // Streaming: two full beats, eight back-to-back reads
        m_ready = 1'b1;
        clear_stats();
        for (int w = 1; w <= 8; w++) mdl_push(8'(w));
        wait_obs(2, 40);
        check("stream_reads",     rinc_cnt, 8);
        check("stream_rinc_run",  max_run, 8);
        check("stream_latency",   first_valid - first_rinc, RATIO + 1);
        check("stream_beat0",     obs_q[0].data, 32'h04030201);
        check("stream_beat1",     obs_q[1].data, 32'h08070605);
        check("stream_keep0",     obs_q[0].keep, 4'hF);
        check("stream_last0",     obs_q[0].last, 1'b0);

        // Backpressure: 12 words, output register plus pack fill, then drain
        base    = obs_q.size();
        m_ready = 1'b0;
        clear_stats();
        for (int w = 0; w < 12; w++) mdl_push(8'(8'h10 + w));
        tick(25);
        check("bp_reads_blocked", rinc_cnt, 8);
        check("bp_valid_held",    m_valid, 1'b1);
        check("bp_no_transfer",   obs_q.size(), base);
        for (int k = 0; k < 3; k++) begin
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
            tick(8);
            check("bp_one_per_pulse", obs_q.size(), base + k + 1);
        end
        check("bp_total_reads",   rinc_cnt, 12);
        check("bp_first_beat",    obs_q[base].data, 32'h13121110);
        m_ready = 1'b1;

        // Flush while the third read is pending
        base = obs_q.size();
        mdl_push(8'hAA);
        mdl_push(8'hBB);
        mdl_push(8'hCC);
        mdl_flush();
        tick(4);
        clear_stats();
        pulse_flush();
        wait_obs(base + 1, 20);
        check("flush_pend_latency", first_valid, 2);
        check("flush_part_data",    obs_q[base].data, 32'h00CCBBAA);
        check("flush_part_keep",    obs_q[base].keep, 4'h7);
        check("flush_part_last",    obs_q[base].last, 1'b1);

        // Flush with nothing pending: one-cycle latency
        base = obs_q.size();
        mdl_push(8'h11);
        mdl_push(8'h22);
        mdl_flush();
        tick(10);
        clear_stats();
        pulse_flush();
        wait_obs(base + 1, 20);
        check("flush_idle_latency", first_valid, 1);
        check("flush_two_data",     obs_q[base].data, 32'h00002211);
        check("flush_two_keep",     obs_q[base].keep, 4'h3);

        // Flush on an empty pack emits nothing; packing resumes
        tick(3);
        base = obs_q.size();
        clear_stats();
        pulse_flush();
        tick(5);
        check("empty_flush_no_valid", first_valid, -1);
        check("empty_flush_no_beat",  obs_q.size(), base);
        for (int w = 0; w < 4; w++) mdl_push(8'(8'h31 + w));
        wait_obs(base + 1, 20);
        check("resume_after_empty", obs_q[base].data, 32'h34333231);

        // Flush exactly as the pack fills: single normal beat
        base = obs_q.size();
        for (int w = 0; w < 4; w++) mdl_push(8'(8'h41 + w));
        mdl_flush();
        tick(5);
        pulse_flush();
        tick(10);
        check("fill_flush_one_beat", obs_q.size(), base + 1);
        check("fill_flush_data",     obs_q[base].data, 32'h44434241);
        check("fill_flush_last",     obs_q[base].last, 1'b0);
        for (int w = 0; w < 4; w++) mdl_push(8'(8'h51 + w));
        wait_obs(base + 2, 20);

        // Reset mid-beat: held beat and two captured words are dropped
        m_ready = 1'b0;
        for (int w = 0; w < 6; w++) mdl_push(8'(8'h61 + w));
        tick(15);
        check("pre_rst_valid", m_valid, 1'b1);
        #2 rrst = 1'b1;
        #2;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data",  m_data,  32'h0);
        check("mid_rst_m_keep",  m_keep,  4'h0);
        check("mid_rst_m_last",  m_last,  1'b0);
        check("mid_rst_rinc",    rinc,    1'b0);
        exp_q.delete();
        acc_q.delete();
        tick(2);
        rrst    = 1'b0;
        m_ready = 1'b1;
        base    = obs_q.size();
        for (int w = 0; w < 4; w++) mdl_push(8'(8'h71 + w));
        wait_obs(base + 1, 20);
        check("post_rst_lane0", obs_q[base].data, 32'h74737271);

        // Single word followed by an empty FIFO
        base = obs_q.size();
        clear_stats();
        mdl_push(8'h5A);
        mdl_flush();
`ifdef PACKER_TIMEOUT_EN
        wait_obs(base + 1, 40);
        check("timeout_latency", first_valid, TIMEOUT + 4);
`else
        tick(40);
        check("no_timeout_beat",  obs_q.size(), base);
        check("no_timeout_valid", m_valid, 1'b0);
        pulse_flush();
        wait_obs(base + 1, 10);
`endif
        check("single_data", obs_q[base].data, 32'h0000005A);
        check("single_keep", obs_q[base].keep, 4'h1);
        check("single_last", obs_q[base].last, 1'b1);

        tick(5);
        check("all_beats_delivered", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side packer in the `rclk` domain, directly downstream of the asynchronous FIFO's read port. It pulls `WIDTH`-bit words with `rinc`/`rempty`/`rdata`, accounting for the FIFO RAM's one-cycle registered read. It packs `RATIO` consecutive words into one `RATIO*WIDTH`-bit beat on a valid/ready output stream. An explicit flush (and optionally an idle timeout) emits a partial beat with a lane-keep mask.

## Interface
- `WIDTH`, 8: FIFO word width.
- `RATIO`, 4: words per output beat; power of two, ≥2.
- `TIMEOUT`, 16: idle cycles before auto-flush; used only with `PACKER_TIMEOUT_EN`; ≥1.

- `rclk`  in  1  clock; single clock domain, the FIFO read clock.
- `rrst`  in  1  reset, asynchronous, active-high.
- `rempty`  in  1  FIFO empty flag.
- `rdata`  in  WIDTH  FIFO read data; valid the cycle after an accepted `rinc`.
- `rinc`  out  1  read request; never asserted while `rempty`=1.
- `flush`  in  1  single-cycle pulse: emit the current partial beat.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  RATIO*WIDTH  packed beat; the first word received sits in lane 0 = `[WIDTH-1:0]`.
- `m_keep`  out  RATIO  per-lane valid mask, contiguous from lane 0.
- `m_last`  out  1  beat closed by a flush or timeout.

## Operation
- State:
  - `cnt`: lanes captured into the pack register, 0..RATIO-1.
  - `pend`: 1 when a read was issued last cycle and its data lands this cycle.
  - Output register: `m_*`.
  - `flush_pend` latch.
- Occupancy `occ = cnt + pend`.
- `rinc = !rempty && !flush_pend && !rrst && (occ < RATIO || close_now)`.
  - `close_now`: the final lane is captured this cycle and the output register is empty or `m_ready`=1.
- Capture: when `pend`=1, `rdata` is written into lane `cnt`, then `cnt` increments.
- Full beat: the cycle lane RATIO-1 is captured, the pack moves to the output register if it is free (`!m_valid || m_ready`).
  - Moved beat: `m_keep` all ones, `m_last`=0, and `cnt` returns to 0.
  - Otherwise the pack holds full and `rinc` stays 0 until the transfer happens.
- Output handshake:
  - A beat transfers when `m_valid && m_ready`.
  - `m_data`, `m_keep` and `m_last` stay stable while `m_valid && !m_ready`.
- Flush:
  - A `flush` pulse sets `flush_pend`, which blocks new reads.
  - Once `pend`=0 and `cnt`>0, the partial beat moves to the output register when it is free: `m_keep` has its low `cnt` bits set, unused lanes are zero, and `m_last`=1.
  - Then `cnt`=0 and `flush_pend` clears.
  - Flush with `cnt`=0 and `pend`=0: no beat is emitted and `flush_pend` clears the next cycle.
  - Flush arriving while a read is pending: the landing word is included in the partial beat.
  - Flush arriving exactly as the pack fills: a normal full beat is emitted and `flush_pend` then clears with no extra beat.
- Reset mid-operation:
  - Clears all state immediately, including words already popped from the FIFO; these are lost by design.
  - `rinc` is 0 while `rrst`=1.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0, `rinc`=0, and all internal state 0.
- Latency from the first `rinc` to `m_valid` for a full beat: RATIO+1 cycles with `rempty`=0 throughout.
- With `m_ready` held at 1 and the FIFO non-empty, throughput is one FIFO word per cycle and one beat per RATIO cycles, with no bubbles.
- Flush to `m_valid`: 1 cycle (`pend`=0) or 2 cycles (`pend`=1), assuming the output register is free.
- A `rempty` rise never cancels a read already issued; `pend` is set from `rinc` qualified by `!rempty` in that same cycle.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - An idle counter counts consecutive cycles with `cnt`>0, `pend`=0 and `rempty`=1.
  - On reaching `TIMEOUT` it raises an internal flush, identical to the `flush` pulse.
  - The counter clears on any capture or flush.
- Not defined: no counter logic; a partial beat is held indefinitely until `flush`, and `TIMEOUT` is ignored.

## Test plan
- Reset: assert `rrst` mid-beat with `cnt`=2 → all outputs are 0 immediately; after release the next beat starts in lane 0.
- Streaming: FIFO preloaded with 0x01..0x08, `m_ready`=1 → beats 0x04030201 then 0x08070605, `m_keep`=0xF, `m_last`=0, with `rinc` high 8 consecutive cycles.
- Backpressure: `m_ready`=0 with 12 words available → one beat is held stable in the output register, `rinc` stops after 8 reads (output register plus full pack), and each later `m_ready` pulse drains exactly one beat.
- Flush partial: 3 words 0xAA,0xBB,0xCC then `flush` while the last read is pending → `m_data`=0x00CCBBAA, `m_keep`=0x7, `m_last`=1.
- Flush on empty pack: `flush` with `cnt`=0 → no `m_valid`, and normal packing resumes afterwards.
- Timeout (macro defined, `TIMEOUT`=16): 1 word 0x5A, then FIFO empty → after 16 idle cycles `m_data`=0x0000005A, `m_keep`=0x1, `m_last`=1; without the macro, no beat is emitted.
